wb_echo_master: RTL and testbench

Wishbone initiator that autonomously drives the trigger-echo peripheral, so the theremin datapath gets distance samples without CPU involvement. After reset it writes the trigger configuration word to the peripheral's config register, then periodically reads the 16-bit echo counter and presents each result as a one-cycle-valid sample. Runtime reconfiguration requests are queued and issued ahead of the next poll. The block sits between the theremin tone logic and the peripheral's Wishbone slave port.

---
 rtl/wb_echo_master_pkg.sv | 24 ++
 rtl/wb_echo_master_if.sv | 24 ++
 rtl/wb_echo_master.sv | 170 +++++++++++++++++
 tb/tb_wb_echo_master.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_echo_master_pkg.sv
// Shared types and constants for the Wishbone echo-counter poller.
// Holds the FSM encoding, peripheral register map and config word layout.
package wb_echo_master_pkg;

    typedef enum logic [1:0] {
        INIT_WR = 2'd0,
        WAIT    = 2'd1,
        CFG_WR  = 2'd2,
        RD      = 2'd3
    } state_e;

    localparam logic [31:0] CFG_OFS = 32'h0000_0000;
    localparam logic [31:0] CNT_OFS = 32'h0000_0004;

    // Config word is {clr, t_sel2[3:0], t_sel1[3:0]}.
    localparam int SEL_FIELD_W = 4;
    localparam int CFG_W       = 1 + 2 * SEL_FIELD_W;
    localparam int SAMPLE_W    = 16;

    function automatic logic [31:0] cfgWord(input logic [CFG_W-1:0] cfg);
        return {{(32 - CFG_W){1'b0}}, cfg};
    endfunction

endpackage

// File: rtl/wb_echo_master_if.sv
// Wishbone classic single-beat bus between the echo poller and the peripheral.
// Signal names follow the initiator's point of view.
interface wb_echo_master_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_echo_master.sv
// Autonomous Wishbone initiator: configures the trigger-echo peripheral after
// reset, then polls its echo counter and publishes each reading as a sample.
module wb_echo_master
    import wb_echo_master_pkg::*;
#(
    parameter logic [31:0]      BASE_ADR = 32'h0000_0000,
    parameter int               POLL_DIV = 50000,
    parameter logic [CFG_W-1:0] CFG_INIT = 9'h002,
    parameter int               TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset,
    wb_echo_master_if.master    wb,
    input  logic [CFG_W-1:0]    cfg_i,
    input  logic                cfg_wr_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    output logic                timeout_o,
    output logic                busy_o
);

    localparam int POLL_W = $clog2(POLL_DIV);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [POLL_W-1:0]   pollCnt_q, pollCnt_d;
    logic [TMO_W-1:0]    tmoCnt_q, tmoCnt_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [31:0]         adr_q, adr_d;
    logic [31:0]         dat_q, dat_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sampleValid_q, sampleValid_d;
    logic                timeout_q, timeout_d;
    logic                pending_q, pending_d;
    logic [CFG_W-1:0]    pendCfg_q, pendCfg_d;

    logic [31-SAMPLE_W:0] unusedDatHi;
    assign unusedDatHi = wb.wb_dat_i[31:SAMPLE_W];

    // A transaction state with cyc low means "launch now"; cyc high means "waiting for ack".
    always_comb begin
        state_d       = state_q;
        pollCnt_d     = pollCnt_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        sample_d      = sample_q;
        sampleValid_d = 1'b0;
        timeout_d     = 1'b0;
        pending_d     = pending_q;
        pendCfg_d     = pendCfg_q;

        case (state_q)
            INIT_WR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = BASE_ADR + CFG_OFS;
                    dat_d = cfgWord(CFG_INIT);
                end else if (wb.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pollCnt_q == POLL_LAST) begin
                    pollCnt_d = '0;
                    cyc_d     = 1'b1;
                    if (pending_q) begin
                        state_d = CFG_WR;
                        we_d    = 1'b1;
                        adr_d   = BASE_ADR + CFG_OFS;
                        dat_d   = cfgWord(pendCfg_q);
                    end else begin
                        state_d = RD;
                        we_d    = 1'b0;
                        adr_d   = BASE_ADR + CNT_OFS;
                    end
                end else begin
                    pollCnt_d = pollCnt_q + 1'b1;
                end
            end
            CFG_WR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = BASE_ADR + CFG_OFS;
                    dat_d = cfgWord(pendCfg_q);
                end else if (wb.wb_ack_i) begin
                    cyc_d     = 1'b0;
                    pending_d = 1'b0;
                    state_d   = RD;
                end
            end
            RD: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = BASE_ADR + CNT_OFS;
                end else if (wb.wb_ack_i) begin
                    cyc_d         = 1'b0;
                    sample_d      = wb.wb_dat_i[SAMPLE_W-1:0];
                    sampleValid_d = 1'b1;
                    state_d       = WAIT;
                end
            end
            default: state_d = INIT_WR;
        endcase

        // Abort leaves pending untouched so a failed reconfig is retried next slot.
        if (cyc_q && !wb.wb_ack_i && (tmoCnt_q == TMO_LAST)) begin
            cyc_d     = 1'b0;
            timeout_d = 1'b1;
            state_d   = WAIT;
        end

        if (cfg_wr_i) begin
            pending_d = 1'b1;
            pendCfg_d = cfg_i;
        end

        tmoCnt_d = (cyc_q && cyc_d) ? tmoCnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT_WR;
            pollCnt_q     <= '0;
            tmoCnt_q      <= '0;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            dat_q         <= '0;
            sample_q      <= '0;
            sampleValid_q <= 1'b0;
            timeout_q     <= 1'b0;
            pending_q     <= 1'b0;
            pendCfg_q     <= CFG_INIT;
        end else begin
            state_q       <= state_d;
            pollCnt_q     <= pollCnt_d;
            tmoCnt_q      <= tmoCnt_d;
            cyc_q         <= cyc_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sample_q      <= sample_d;
            sampleValid_q <= sampleValid_d;
            timeout_q     <= timeout_d;
            pending_q     <= pending_d;
            pendCfg_q     <= pendCfg_d;
        end
    end

    assign wb.wb_cyc_o    = cyc_q;
    assign wb.wb_stb_o    = cyc_q;
    assign wb.wb_we_o     = cyc_q & we_q;
    assign wb.wb_adr_o    = adr_q;
    assign wb.wb_sel_o    = cyc_q ? 4'hF : 4'h0;
    assign wb.wb_dat_o    = dat_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sampleValid_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = cyc_q;

endmodule

// File: tb/tb_wb_echo_master.sv
// Bench for wb_echo_master: a one-cycle-ack slave records every bus cycle and
// output pulse, and scenario tasks compare them with a slot-level model.
module tb_wb_echo_master;

    localparam int          POLL_DIV = 24;
    localparam int          TIMEOUT  = 64;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam logic [8:0]  CFG_INIT = 9'h002;
    localparam logic [31:0] CFG_ADR  = BASE;
    localparam logic [31:0] CNT_ADR  = BASE + 32'h4;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdat;
        int          len;
        int          gap;
        bit          acked;
        int          ackCycle;
        int          endCycle;
    } txn_t;

    typedef struct {
        int          startCycle;
        int          len;
        logic [15:0] sample;
    } pulse_t;

    logic        clk;
    logic        reset;
    logic [8:0]  cfg_i;
    logic        cfg_wr_i;
    logic [15:0] sample_o;
    logic        sample_valid_o;
    logic        timeout_o;
    logic        busy_o;

    wb_echo_master_if bus ();

    wb_echo_master #(
        .BASE_ADR (BASE),
        .POLL_DIV (POLL_DIV),
        .CFG_INIT (CFG_INIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb             (bus),
        .cfg_i          (cfg_i),
        .cfg_wr_i       (cfg_wr_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .timeout_o      (timeout_o),
        .busy_o         (busy_o)
    );

    int checks   = 0;
    int failures = 0;

    // Slot-level reference: what the next poll slot should do and what sample_o holds.
    logic        mdlPending;
    logic [8:0]  mdlCfg;
    logic [15:0] mdlSample;

    logic [31:0] rdData;
    bit          ackReads;

    int     cycNum    = 0;
    int     lastEnd   = 0;
    bit     prevCyc   = 0;
    bit     prevValid = 0;
    bit     prevTmo   = 0;
    txn_t   cur;
    pulse_t curV;
    pulse_t curT;
    txn_t   txnQ[$];
    pulse_t validQ[$];
    pulse_t tmoQ[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish within 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    // Slave and monitor: acks every write and (when enabled) every read in the
    // second cycle of cyc, and logs cycles plus sample_valid/timeout pulses.
    always @(negedge clk) begin
        cycNum++;
        if (bus.wb_cyc_o) begin
            if (!prevCyc) begin
                cur.we       = bus.wb_we_o;
                cur.adr      = bus.wb_adr_o;
                cur.dat      = bus.wb_dat_o;
                cur.sel      = bus.wb_sel_o;
                cur.rdat     = rdData;
                cur.len      = 0;
                cur.gap      = cycNum - lastEnd;
                cur.acked    = 0;
                cur.ackCycle = -1;
            end
            cur.len++;
            if (bus.wb_stb_o && cur.len == 2 && (cur.we || ackReads)) begin
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = cur.rdat;
                cur.acked    = 1;
                cur.ackCycle = cycNum;
            end else begin
                bus.wb_ack_i = 1'b0;
                bus.wb_dat_i = 32'hDEAD_BEEF;
            end
        end else begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 32'hDEAD_BEEF;
            if (prevCyc) begin
                cur.endCycle = cycNum;
                txnQ.push_back(cur);
                lastEnd = cycNum;
            end
        end
        prevCyc = bus.wb_cyc_o;

        if (sample_valid_o && !prevValid) begin
            curV.startCycle = cycNum;
            curV.len        = 0;
            curV.sample     = sample_o;
        end
        if (sample_valid_o) curV.len++;
        if (!sample_valid_o && prevValid) validQ.push_back(curV);
        prevValid = sample_valid_o;

        if (timeout_o && !prevTmo) begin
            curT.startCycle = cycNum;
            curT.len        = 0;
            curT.sample     = sample_o;
        end
        if (timeout_o) curT.len++;
        if (!timeout_o && prevTmo) tmoQ.push_back(curT);
        prevTmo = timeout_o;
    end

    task automatic waitTxn(input int limit, output txn_t t, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (txnQ.size() > 0) break;
        end
        #1;
        if (txnQ.size() > 0) begin
            t  = txnQ.pop_front();
            ok = 1;
        end
    endtask

    task automatic waitPulse(input bit isTmo, input int limit, output pulse_t p, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if ((isTmo ? tmoQ.size() : validQ.size()) > 0) break;
        end
        #1;
        if (isTmo && tmoQ.size() > 0) begin
            p  = tmoQ.pop_front();
            ok = 1;
        end else if (!isTmo && validQ.size() > 0) begin
            p  = validQ.pop_front();
            ok = 1;
        end
    endtask

    task automatic applyStimulus(input logic [8:0] cfg);
        cfg_i    = cfg;
        cfg_wr_i = 1'b1;
        @(posedge clk);
        #1;
        cfg_wr_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o} !== 7'h0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %h expected 00", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o});
        end
        checks++;
        if (bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_adr_dat: got %h/%h expected 0/0", bus.wb_adr_o, bus.wb_dat_o);
        end
        checks++;
        if (sample_o !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_sample: got %h expected 0000", sample_o);
        end
        checks++;
        if ({sample_valid_o, timeout_o, busy_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {sample_valid_o, timeout_o, busy_o});
        end
        mdlPending = 1'b0;
        mdlCfg     = CFG_INIT;
        mdlSample  = 16'h0;
    endtask

    task automatic test_init_and_poll();
        txn_t   t;
        pulse_t p;
        bit     ok;
        reset = 1'b0;
        waitTxn(20, t, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL init_seen: got none expected config write");
            return;
        end
        checks++;
        if (t.we !== 1'b1 || t.adr !== CFG_ADR || t.dat !== {23'b0, CFG_INIT} || t.sel !== 4'hF) begin
            failures++;
            $display("[TB] FAIL init_fields: got we=%b adr=%h dat=%h sel=%h expected we=1 adr=%h dat=%h sel=f",
                     t.we, t.adr, t.dat, t.sel, CFG_ADR, {23'b0, CFG_INIT});
        end
        checks++;
        if (t.len != 2 || !t.acked) begin
            failures++;
            $display("[TB] FAIL init_len: got %0d acked=%0d expected 2 acked=1", t.len, t.acked);
        end
        for (int i = 0; i < 4; i++) begin
            rdData = $urandom;
            waitTxn(POLL_DIV + 10, t, ok);
            checks++;
            if (!ok || t.we !== 1'b0 || t.adr !== CNT_ADR || t.sel !== 4'hF) begin
                failures++;
                $display("[TB] FAIL poll_fields: got ok=%0d we=%b adr=%h sel=%h expected ok=1 we=0 adr=%h sel=f",
                         ok, t.we, t.adr, t.sel, CNT_ADR);
                return;
            end
            checks++;
            if (t.gap != POLL_DIV || t.len != 2) begin
                failures++;
                $display("[TB] FAIL poll_timing: got gap=%0d len=%0d expected gap=%0d len=2", t.gap, t.len, POLL_DIV);
            end
            mdlSample = rdData[15:0];
            waitPulse(1'b0, 5, p, ok);
            checks++;
            if (!ok || p.sample !== mdlSample || p.startCycle != t.ackCycle + 1 || p.len != 1) begin
                failures++;
                $display("[TB] FAIL poll_sample: got ok=%0d sample=%h at=%0d len=%0d expected sample=%h at=%0d len=1",
                         ok, p.sample, p.startCycle, p.len, mdlSample, t.ackCycle + 1);
            end
        end
    endtask

    task automatic test_read_pattern();
        txn_t   t;
        pulse_t p;
        bit     ok;
        rdData = 32'hABCD_1234;
        waitTxn(POLL_DIV + 10, t, ok);
        mdlSample = 16'h1234;
        waitPulse(1'b0, 5, p, ok);
        checks++;
        if (!ok || p.sample !== 16'h1234 || p.len != 1 || p.startCycle != t.ackCycle + 1) begin
            failures++;
            $display("[TB] FAIL pattern_sample: got ok=%0d sample=%h len=%0d at=%0d expected 1234 len=1 at=%0d",
                     ok, p.sample, p.len, p.startCycle, t.ackCycle + 1);
        end
        checks++;
        if (sample_o !== mdlSample) begin
            failures++;
            $display("[TB] FAIL pattern_hold: got %h expected %h", sample_o, mdlSample);
        end
    endtask

    task automatic test_reconfig(input string name, input int nReq, input bit useRandom,
                                 input logic [8:0] v0, input logic [8:0] v1);
        txn_t       t;
        pulse_t     p;
        bit         ok;
        logic [8:0] v;
        for (int i = 0; i < nReq; i++) begin
            v = useRandom ? 9'($urandom_range(0, 511)) : ((i == 0) ? v0 : v1);
            applyStimulus(v);
            mdlPending = 1'b1;
            mdlCfg     = v;
        end
        rdData = $urandom;
        waitTxn(POLL_DIV + 10, t, ok);
        checks++;
        if (!ok || t.we !== mdlPending || t.adr !== CFG_ADR || t.dat !== {23'b0, mdlCfg} || t.gap != POLL_DIV) begin
            failures++;
            $display("[TB] FAIL %s_write: got ok=%0d we=%b adr=%h dat=%h gap=%0d expected we=1 adr=%h dat=%h gap=%0d",
                     name, ok, t.we, t.adr, t.dat, t.gap, CFG_ADR, {23'b0, mdlCfg}, POLL_DIV);
            return;
        end
        mdlPending = 1'b0;
        waitTxn(10, t, ok);
        checks++;
        if (!ok || t.we !== 1'b0 || t.adr !== CNT_ADR || t.gap != 1 || !t.acked) begin
            failures++;
            $display("[TB] FAIL %s_follow_read: got ok=%0d we=%b adr=%h gap=%0d expected we=0 adr=%h gap=1",
                     name, ok, t.we, t.adr, t.gap, CNT_ADR);
            return;
        end
        mdlSample = rdData[15:0];
        waitPulse(1'b0, 5, p, ok);
        checks++;
        if (!ok || p.sample !== mdlSample) begin
            failures++;
            $display("[TB] FAIL %s_sample: got ok=%0d sample=%h expected %h", name, ok, p.sample, mdlSample);
        end
        rdData = $urandom;
        waitTxn(POLL_DIV + 10, t, ok);
        checks++;
        if (!ok || t.we !== mdlPending || t.adr !== CNT_ADR || t.gap != POLL_DIV) begin
            failures++;
            $display("[TB] FAIL %s_next_slot: got ok=%0d we=%b adr=%h gap=%0d expected we=0 adr=%h gap=%0d",
                     name, ok, t.we, t.adr, t.gap, CNT_ADR, POLL_DIV);
            return;
        end
        mdlSample = rdData[15:0];
        waitPulse(1'b0, 5, p, ok);
    endtask

    task automatic test_timeout();
        txn_t   t;
        pulse_t p;
        bit     ok;
        ackReads = 0;
        rdData   = $urandom;
        waitTxn(POLL_DIV + TIMEOUT + 10, t, ok);
        checks++;
        if (!ok || t.we !== 1'b0 || t.acked || t.len != TIMEOUT) begin
            failures++;
            $display("[TB] FAIL timeout_cycle: got ok=%0d we=%b acked=%0d len=%0d expected we=0 acked=0 len=%0d",
                     ok, t.we, t.acked, t.len, TIMEOUT);
            return;
        end
        waitPulse(1'b1, 5, p, ok);
        checks++;
        if (!ok || p.len != 1 || p.startCycle != t.endCycle) begin
            failures++;
            $display("[TB] FAIL timeout_pulse: got ok=%0d len=%0d at=%0d expected len=1 at=%0d",
                     ok, p.len, p.startCycle, t.endCycle);
        end
        ackReads = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tmoQ.size() != 0 || validQ.size() != 0 || sample_o !== mdlSample) begin
            failures++;
            $display("[TB] FAIL timeout_quiet: got tmo=%0d valid=%0d sample=%h expected 0 0 %h",
                     tmoQ.size(), validQ.size(), sample_o, mdlSample);
        end
        rdData = $urandom;
        waitTxn(POLL_DIV + 10, t, ok);
        checks++;
        if (!ok || t.we !== 1'b0 || !t.acked || t.gap != POLL_DIV) begin
            failures++;
            $display("[TB] FAIL timeout_recover: got ok=%0d we=%b acked=%0d gap=%0d expected we=0 acked=1 gap=%0d",
                     ok, t.we, t.acked, t.gap, POLL_DIV);
            return;
        end
        mdlSample = rdData[15:0];
        waitPulse(1'b0, 5, p, ok);
        checks++;
        if (!ok || p.sample !== mdlSample) begin
            failures++;
            $display("[TB] FAIL timeout_recover_sample: got ok=%0d sample=%h expected %h", ok, p.sample, mdlSample);
        end
    endtask

    task automatic test_reset_mid();
        txn_t   t;
        pulse_t p;
        bit     ok;
        bit     found;
        found = 0;
        for (int i = 0; i < POLL_DIV + 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.wb_cyc_o && !bus.wb_we_o) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL rstmid_read_seen: got none expected read cycle");
            return;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        mdlPending = 1'b0;
        mdlCfg     = CFG_INIT;
        mdlSample  = 16'h0;
        checks++;
        if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || busy_o !== 1'b0 || sample_o !== mdlSample) begin
            failures++;
            $display("[TB] FAIL rstmid_drop: got cyc=%b stb=%b busy=%b sample=%h expected 0 0 0 %h",
                     bus.wb_cyc_o, bus.wb_stb_o, busy_o, sample_o, mdlSample);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        waitTxn(5, t, ok);
        checks++;
        if (!ok || t.acked) begin
            failures++;
            $display("[TB] FAIL rstmid_aborted: got ok=%0d acked=%0d expected ok=1 acked=0", ok, t.acked);
        end
        waitTxn(20, t, ok);
        checks++;
        if (!ok || t.we !== 1'b1 || t.adr !== CFG_ADR || t.dat !== {23'b0, mdlCfg} || !t.acked) begin
            failures++;
            $display("[TB] FAIL rstmid_init: got ok=%0d we=%b adr=%h dat=%h expected we=1 adr=%h dat=%h",
                     ok, t.we, t.adr, t.dat, CFG_ADR, {23'b0, mdlCfg});
        end
        checks++;
        if (validQ.size() != 0 || tmoQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL rstmid_no_pulse: got valid=%0d tmo=%0d expected 0 0", validQ.size(), tmoQ.size());
        end
        rdData = $urandom;
        waitTxn(POLL_DIV + 10, t, ok);
        mdlSample = rdData[15:0];
        waitPulse(1'b0, 5, p, ok);
        checks++;
        if (!ok || p.sample !== mdlSample || t.gap != POLL_DIV) begin
            failures++;
            $display("[TB] FAIL rstmid_resume: got ok=%0d sample=%h gap=%0d expected sample=%h gap=%0d",
                     ok, p.sample, t.gap, mdlSample, POLL_DIV);
        end
    endtask

    initial begin
        reset    = 1'b1;
        cfg_i    = 9'h0;
        cfg_wr_i = 1'b0;
        rdData   = 32'h0;
        ackReads = 1;
        $display("[TB] starting wb_echo_master bench");
        test_reset();
        test_init_and_poll();
        test_read_pattern();
        test_reconfig("cfg_1f3", 1, 1'b0, 9'h1F3, 9'h000);
        test_reconfig("last_wins", 2, 1'b0, 9'h011, 9'h022);
        test_reconfig("cfg_rand", 3, 1'b1, 9'h000, 9'h000);
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
